// File: rtl/wb_pkg.sv
// Shared types and constants for the integer-register writeback path.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    rd_onehot = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword of a load word and sign/zero-extends it.
// Purely combinational so the store-forwarding path can reuse it.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Unknown encodings fall back to the full word.
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h000000, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Regfile write-port arbiter: ALU results vs. queued load responses with starvation relief.
// Optional WB_LOAD_BYPASS_EN lets a load skip the empty queue when the port is idle.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [2:0]  lsu_funct3,
  input  logic [1:0]  lsu_addr_lo,
  input  logic [31:0] lsu_rdata,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        wb_write,
  output logic [31:0] pending_mask
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [3:0]       LIMIT_C = 4'(STARVE_LIMIT);

  wb_entry_t        mem_q [QUEUE_DEPTH];
  wb_entry_t        mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       starve_q, starve_d;
  logic             alu_stall_q, alu_stall_d;
  logic             wb_write_q, wb_write_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic [31:0] load_data;
  wb_entry_t   head;
  logic        fifo_empty, fifo_full, lsu_accept;
  logic        alu_cand, head_cand, bypass, enq;
  logic        alu_win, head_win;
  logic [31:0] pend;

  load_align u_load_align (
    .funct3  (lsu_funct3),
    .addr_lo (lsu_addr_lo),
    .rdata   (lsu_rdata),
    .data    (load_data)
  );

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign lsu_accept = lsu_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign alu_cand   = alu_valid && (alu_rd != 5'd0);
  assign head_cand  = !fifo_empty;

`ifdef WB_LOAD_BYPASS_EN
  assign bypass = lsu_accept && (lsu_rd != 5'd0) && fifo_empty && !alu_cand && !alu_stall_q;
`else
  assign bypass = 1'b0;
`endif

  // rd==0 loads are acknowledged but never occupy a slot.
  assign enq = lsu_accept && (lsu_rd != 5'd0) && !bypass;

  always_comb begin
    head_win = 1'b0;
    alu_win  = 1'b0;
    if (alu_stall_q) begin
      head_win = head_cand;
    end else if (alu_cand) begin
      alu_win = 1'b1;
    end else begin
      head_win = head_cand;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = '{rd: lsu_rd, data: load_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (head_win) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({enq, head_win})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d    = starve_q;
    alu_stall_d = 1'b0;
    if (head_win) begin
      starve_d = '0;
    end else if (head_cand) begin
      if (starve_q != LIMIT_C) begin
        starve_d = starve_q + 4'd1;
      end
      alu_stall_d = (starve_d == LIMIT_C);
    end

    wb_write_d = alu_win || head_win || bypass;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (head_win) begin
      wb_addr_d = head.rd;
      wb_data_d = head.data;
    end else if (alu_win) begin
      wb_addr_d = alu_rd;
      wb_data_d = alu_result;
    end else if (bypass) begin
      wb_addr_d = lsu_rd;
      wb_data_d = load_data;
    end
  end

  // Only occupied slots, walked from the head, contribute to the mask.
  always_comb begin
    pend = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        pend = pend | rd_onehot(mem_q[rd_ptr_q + PTR_W'(i)].rd);
      end
    end
    pend[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      wb_write_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      wb_write_q  <= wb_write_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign lsu_ready    = !fifo_full;
  assign alu_stall    = alu_stall_q;
  assign wb_write     = wb_write_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign pending_mask = pend;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: queue-based reference model plus directed literals.
module tb_writeback_unit;

  localparam int QD    = 2;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic [31:0] lsu_rdata;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_write;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  writeback_unit #(.QUEUE_DEPTH(QD), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_result   (alu_result),
    .alu_stall    (alu_stall),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_funct3   (lsu_funct3),
    .lsu_addr_lo  (lsu_addr_lo),
    .lsu_rdata    (lsu_rdata),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_write     (wb_write),
    .pending_mask (pending_mask)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_stall  = 1'b0;
  bit          exp_w    = 1'b0;
  logic [4:0]  exp_a    = '0;
  logic [31:0] exp_d    = '0;
  bit          hold_alu = 1'b0;
  bit          hold_lsu = 1'b0;
  int          checks   = 0;
  int          errors   = 0;
  bit          log_en   = 1'b0;
  logic [4:0]  load_log[$];
  int          post_rst_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock of the reference behaviour, from the inputs the bench is presenting.
  task automatic model_cycle();
    bit          acc, ac, hc, byp, hw;
    ent_t        h;
    logic [31:0] f;
    acc = lsu_valid && (mq.size() < QD);
    f   = fmt_model(lsu_funct3, lsu_addr_lo, lsu_rdata);
    ac  = alu_valid && (alu_rd != 5'd0);
    hc  = (mq.size() != 0);
    byp = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    byp = acc && (lsu_rd != 5'd0) && !hc && !ac && !m_stall;
`endif
    hw    = 1'b0;
    exp_w = 1'b0;
    if (m_stall) hw = hc;
    else if (ac) begin
      exp_w = 1'b1; exp_a = alu_rd; exp_d = alu_result;
    end else if (hc) hw = 1'b1;
    else if (byp) begin
      exp_w = 1'b1; exp_a = lsu_rd; exp_d = f;
    end
    if (hw) begin
      h = mq.pop_front();
      exp_w = 1'b1; exp_a = h.rd; exp_d = h.data;
    end
    hold_alu = m_stall;
    hold_lsu = lsu_valid && !acc;
    if (acc && (lsu_rd != 5'd0) && !byp) mq.push_back('{rd: lsu_rd, data: f});
    if (hw) m_starve = 0;
    else if (hc) m_starve++;
    m_stall = hc && !hw && (m_starve == LIMIT);
  endtask

  task automatic compare();
    chk("wb_write", 32'(wb_write), 32'(exp_w));
    if (exp_w) begin
      chk("wb_addr", 32'(wb_addr), 32'(exp_a));
      chk("wb_data", wb_data, exp_d);
    end
    chk("alu_stall", 32'(alu_stall), 32'(m_stall));
    chk("lsu_ready", 32'(lsu_ready), 32'(mq.size() < QD));
    chk("pending_mask", pending_mask, model_mask());
    if (log_en && wb_write && wb_addr >= 5'd10 && wb_addr <= 5'd12) load_log.push_back(wb_addr);
    if (wb_write) post_rst_writes++;
  endtask

  // Called at a falling edge; upstream hold rules override the requested values.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ares,
                      input bit lv, input logic [4:0] lrd, input logic [2:0] lf3,
                      input logic [1:0] loff, input logic [31:0] ldat);
    if (!hold_alu) begin
      alu_valid = av; alu_rd = ard; alu_result = ares;
    end
    if (!hold_lsu) begin
      lsu_valid = lv; lsu_rd = lrd; lsu_funct3 = lf3; lsu_addr_lo = loff; lsu_rdata = ldat;
    end
    model_cycle();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic alu_only(input logic [4:0] rd, input logic [31:0] res);
    step(1'b1, rd, res, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic load_case(input string nm, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] w, input logic [31:0] lit);
    step(1'b0, '0, '0, 1'b1, 5'd9, f3, off, w);
`ifdef WB_LOAD_BYPASS_EN
    chk({nm, " write at N+1"}, 32'(wb_write), 32'd1);
`else
    chk({nm, " no write at N+1"}, 32'(wb_write), 32'd0);
    idle();
    chk({nm, " write at N+2"}, 32'(wb_write), 32'd1);
`endif
    chk({nm, " addr"}, 32'(wb_addr), 32'd9);
    chk({nm, " data"}, wb_data, lit);
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_funct3 = '0; lsu_addr_lo = '0; lsu_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset wb_write", 32'(wb_write), 32'd0);
    chk("reset wb_addr", 32'(wb_addr), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset alu_stall", 32'(alu_stall), 32'd0);
    chk("reset lsu_ready", 32'(lsu_ready), 32'd1);
    chk("reset pending_mask", pending_mask, 32'd0);
    reset_n = 1'b1;

    // ALU only
    alu_only(5'd5, 32'hDEADBEEF);
    chk("alu write", 32'(wb_write), 32'd1);
    chk("alu addr", 32'(wb_addr), 32'd5);
    chk("alu data", wb_data, 32'hDEADBEEF);
    alu_only(5'd0, 32'h12345678);
    chk("alu rd0 no write", 32'(wb_write), 32'd0);

    // Load formatting and bypass latency
    load_case("LB",  3'b000, 2'd3, 32'h80FF_0000, 32'hFFFFFF80);
    load_case("LBU", 3'b100, 2'd3, 32'h80FF_0000, 32'h00000080);
    load_case("LH",  3'b001, 2'd2, 32'h8001_1234, 32'hFFFF8001);
    load_case("LHU", 3'b101, 2'd0, 32'h8001_1234, 32'h00001234);

    // Contention and starvation
    step(1'b1, 5'd1, 32'hA000_0000, 1'b1, 5'd7, 3'b010, 2'd0, 32'h0000_0777);
    chk("contend pend7", 32'(pending_mask[7]), 32'd1);
    alu_only(5'd2, 32'hA000_0001);
    chk("contend no stall yet", 32'(alu_stall), 32'd0);
    alu_only(5'd3, 32'hA000_0002);
    alu_only(5'd4, 32'hA000_0003);
    chk("contend stall set", 32'(alu_stall), 32'd1);
    alu_only(5'd5, 32'hA000_0004);
    chk("contend stall one cycle", 32'(alu_stall), 32'd0);
    chk("contend load addr", 32'(wb_addr), 32'd7);
    chk("contend load data", wb_data, 32'h0000_0777);
    chk("contend pend7 cleared", 32'(pending_mask[7]), 32'd0);
    alu_only(5'd6, 32'hA000_0005);
    chk("contend held alu addr", 32'(wb_addr), 32'd5);
    chk("contend held alu data", wb_data, 32'hA000_0004);
    idle();

    // Full FIFO with ALU continuously busy
    log_en = 1'b1;
    load_log.delete();
    step(1'b1, 5'd1, 32'hB000_0000, 1'b1, 5'd10, 3'b010, 2'd0, 32'h1010_1010);
    step(1'b1, 5'd2, 32'hB000_0001, 1'b1, 5'd11, 3'b010, 2'd0, 32'h1111_1111);
    chk("full ready low", 32'(lsu_ready), 32'd0);
    step(1'b1, 5'd3, 32'hB000_0002, 1'b1, 5'd12, 3'b010, 2'd0, 32'h1212_1212);
    chk("full pending mask", pending_mask, 32'h0000_0C00);
    for (int i = 3; i < 20; i++) begin
      step(1'b1, 5'((i % 4) + 1), 32'hB000_0000 + 32'(i), 1'b0, '0, '0, '0, '0);
    end
    log_en = 1'b0;
    chk("full order count", 32'(load_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < load_log.size()) chk("full order", 32'(load_log[i]), 32'(10 + i));
    end
    repeat (4) idle();

    // Reset mid-operation
    step(1'b1, 5'd1, 32'hC000_0000, 1'b1, 5'd13, 3'b010, 2'd0, 32'h1313_1313);
    step(1'b1, 5'd2, 32'hC000_0001, 1'b1, 5'd14, 3'b010, 2'd0, 32'h1414_1414);
    chk("pre-reset wb_write", 32'(wb_write), 32'd1);
    chk("pre-reset pending", pending_mask, 32'h0000_6000);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst wb_write", 32'(wb_write), 32'd0);
    chk("midrst wb_addr", 32'(wb_addr), 32'd0);
    chk("midrst wb_data", wb_data, 32'd0);
    chk("midrst alu_stall", 32'(alu_stall), 32'd0);
    chk("midrst pending", pending_mask, 32'd0);
    chk("midrst lsu_ready", 32'(lsu_ready), 32'd1);
    mq.delete();
    m_starve = 0; m_stall = 1'b0; exp_w = 1'b0; hold_alu = 1'b0; hold_lsu = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    post_rst_writes = 0;
    repeat (6) idle();
    chk("no writes after reset", 32'(post_rst_writes), 32'd0);

    // Randomized traffic: mixed phase, then ALU-heavy phase
    for (int i = 0; i < 1200; i++) begin
      int alu_pct;
      alu_pct = (i < 600) ? 55 : 95;
      step($urandom_range(0, 99) < alu_pct, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
    end
    repeat (12) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
